// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: sequential forward SubBytes engine.
// Takes a 128-bit state over a valid/ready handshake, substitutes LANES bytes
// per cycle through LANES S-box instances, and returns the result over a
// second valid/ready handshake. Latency is 16/LANES cycles from accept.
// Optional build macro AES_SUB_BYTES_CHECK_EN adds inverse S-boxes that
// re-check every substituted byte and raise a sticky err flag on mismatch.
`timescale 1ns/1ps

package aes_sub_bytes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

endpackage

// Forward AES S-box: GF inverse followed by the affine transform.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  import aes_sub_bytes_pkg::*;

  logic [7:0] inv;

  assign inv    = gf_inv(byte_i);
  assign byte_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
endmodule

// Inverse AES S-box: inverse affine transform followed by GF inverse.
module aes_inv_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  import aes_sub_bytes_pkg::*;

  logic [7:0] pre;

  assign pre    = rotl8(byte_i, 1) ^ rotl8(byte_i, 3) ^ rotl8(byte_i, 6) ^ 8'h05;
  assign byte_o = gf_inv(pre);
endmodule

module aes_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic         err
);
  import aes_sub_bytes_pkg::*;

  localparam int NCHUNK = 16 / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $fatal(1, "aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic [8*LANES-1:0] lane_in;    // bytes of the current chunk, lane 0 = lowest byte index
  logic [8*LANES-1:0] sub_bytes;  // S-box outputs for the current chunk
  logic            accept;

  assign accept    = in_valid & in_ready;
  assign out_state = work_q;

  // Select the chunk addressed by the counter out of the working register.
  always_comb begin
    lane_in = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_in[8*l +: 8] = work_q[8*(15 - (int'(cnt_q) * LANES + l)) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .byte_i (lane_in[8*g +: 8]),
      .byte_o (sub_bytes[8*g +: 8])
    );
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> SUB on accept, SUB -> DONE after the last chunk, DONE -> IDLE on out_ready.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)               state_d = ST_SUB;
      ST_SUB:  if (cnt_q == LAST_CHUNK)    state_d = ST_DONE;
      ST_DONE: if (out_ready)              state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_SUB:  busy      = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Working register and chunk counter next values.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        work_d = in_state;
        cnt_d  = '0;
      end
    end else if (state_q == ST_SUB) begin
      for (int l = 0; l < LANES; l++) begin
        work_d[8*(15 - (int'(cnt_q) * LANES + l)) +: 8] = sub_bytes[8*l +: 8];
      end
      cnt_d = (cnt_q == LAST_CHUNK) ? '0 : cnt_q + CW'(1);
    end
  end

  // Working register and counter flops.
  // NOTE: the working register is reset so out_state reads zero after reset and no stale block leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef AES_SUB_BYTES_CHECK_EN
  logic [8*LANES-1:0] back_bytes;
  logic               mismatch;
  logic               err_q;

  for (genvar g = 0; g < LANES; g++) begin : g_chk
    aes_inv_sbox u_inv_sbox (
      .byte_i (sub_bytes[8*g +: 8]),
      .byte_o (back_bytes[8*g +: 8])
    );
  end

  assign mismatch = (state_q == ST_SUB) && (back_bytes != lane_in);

  // Sticky error: set the cycle after any round-trip mismatch, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (mismatch) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Testbench for aes_sub_bytes_seq: three instances (LANES = 1, 4, 16) checked
// against an S-box table derived from the GF(2^8) definition at time zero.
`timescale 1ns/1ps

module tb_aes_sub_bytes_seq;

  localparam int ND = 3;
  localparam int LV [ND] = '{1, 4, 16};

  logic           clk = 1'b0;
  logic           rst_n;
  logic [ND-1:0]  in_valid, in_ready, out_valid, out_ready, busy, err;
  logic [127:0]   in_state  [ND];
  logic [127:0]   out_state [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    aes_sub_bytes_seq #(.LANES(LV[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g]),
      .err       (err[g])
    );
  end

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box straight from the definition: inverse found by search, then the bitwise affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic void build_tables();
    logic [7:0] c;
    logic [7:0] v;
    logic [7:0] s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      v = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) v = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
    for (int a = 0; a < 256; a++) inv_t[sbox_t[a]] = 8'(a);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] blk);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_t[blk[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] blk);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_t[blk[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [127:0] blk);
    int t = 0;
    while (!in_ready[d] && t < 100) begin
      tick();
      t++;
    end
    if (!in_ready[d]) check($sformatf("in_ready_timeout_d%0d", d), 128'(in_ready[d]), 128'(1));
    in_valid[d] = 1'b1;
    in_state[d] = blk;
    tick();
    in_valid[d] = 1'b0;
    in_state[d] = rnd128();  // later changes must not reach the result
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid[d]) check($sformatf("out_valid_timeout_d%0d", d), 128'(out_valid[d]), 128'(1));
  endtask

  task automatic pop(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check($sformatf("pop_valid_d%0d", d), 128'(out_valid[d]), 128'(0));
  endtask

  task automatic run(input int d, input logic [127:0] blk, input string tag);
    int lat;
    send(d, blk);
    wait_valid(d, lat);
    check($sformatf("%s_lat_d%0d", tag, d), 128'(lat), 128'(16 / LV[d]));
    check($sformatf("%s_out_d%0d", tag, d), out_state[d], model(blk));
    check($sformatf("%s_err_d%0d", tag, d), 128'(err[d]), 128'(0));
    pop(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk, blk_b, exp_a, got;
    int lat;

    build_tables();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < ND; d++) in_state[d] = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_err",       128'(err),       128'(0));
    for (int d = 0; d < ND; d++) check($sformatf("rst_out_state_d%0d", d), out_state[d], 128'(0));
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 128'(in_ready), 128'(3'b111));

    // Single-byte vector, LANES=4.
    send(1, 128'h00535301_FF000000_00000000_000000FF);
    wait_valid(1, lat);
    check("single_lat", 128'(lat), 128'(4));
    check("single_out", out_state[1], 128'h63EDED7C_16636363_63636363_63636316);
    pop(1);

    // FIPS-197 round-1 SubBytes on every lane count, plus the model.
    for (int d = 0; d < ND; d++) begin
      send(d, 128'h193DE3BEA0F4E22B9AC68D2AE9F84808);
      wait_valid(d, lat);
      check($sformatf("fips_lat_d%0d", d), 128'(lat), 128'(16 / LV[d]));
      check($sformatf("fips_out_d%0d", d), out_state[d], 128'hD42711AEE0BF98F1B8B45DE51E415230);
      pop(d);
    end

    // Exhaustive byte sweep, with round-trip through the inverse table.
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = 8'(b * 16 + k);
      send(1, blk);
      wait_valid(1, lat);
      got = out_state[1];
      check($sformatf("sweep_out_%0d", b), got, model(blk));
      check($sformatf("sweep_inv_%0d", b), inv_model(got), blk);
      check($sformatf("sweep_err_%0d", b), 128'(err[1]), 128'(0));
      pop(1);
    end

    // Random blocks on every instance.
    for (int i = 0; i < 8; i++)
      for (int d = 0; d < ND; d++) run(d, rnd128(), $sformatf("rand%0d", i));

    // Backpressure: hold DONE, offer a second block meanwhile.
    blk   = rnd128();
    blk_b = rnd128();
    exp_a = model(blk);
    send(1, blk);
    wait_valid(1, lat);
    in_valid[1] = 1'b1;
    in_state[1] = blk_b;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), 128'(out_valid[1]), 128'(1));
      check($sformatf("bp_state_%0d", i), out_state[1], exp_a);
      check($sformatf("bp_ready_%0d", i), 128'(in_ready[1]), 128'(0));
      tick();
    end
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    check("bp_after_pop_valid", 128'(out_valid[1]), 128'(0));
    check("bp_after_pop_ready", 128'(in_ready[1]), 128'(1));
    tick();
    in_valid[1] = 1'b0;
    in_state[1] = rnd128();
    check("bp_second_accept", 128'(busy[1]), 128'(1));
    wait_valid(1, lat);
    check("bp_second_lat", 128'(lat), 128'(4));
    check("bp_second_out", out_state[1], model(blk_b));
    pop(1);

    // Reset in the middle of SUB on the 16-cycle instance.
    send(0, rnd128());
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_busy",  128'(busy[0]),      128'(0));
    check("mid_rst_state", out_state[0],       128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_ready", 128'(in_ready[0]), 128'(1));
    send(0, 128'(0));
    wait_valid(0, lat);
    check("mid_rst_zero_out", out_state[0], {16{8'h63}});
    pop(0);

`ifdef AES_SUB_BYTES_CHECK_EN
    // Corrupt one SUB cycle of the S-box outputs; err must rise one edge later and stick.
    send(1, 128'(0));
    check("chk_err_before", 128'(err[1]), 128'(0));
    force g_dut[1].u_dut.sub_bytes = '0;
    tick();
    release g_dut[1].u_dut.sub_bytes;
    check("chk_err_rise", 128'(err[1]), 128'(1));
    wait_valid(1, lat);
    pop(1);
    repeat (3) tick();
    check("chk_err_sticky", 128'(err[1]), 128'(1));
    rst_n = 1'b0;
    #1;
    check("chk_err_reset", 128'(err[1]), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
`else
    check("chk_err_tied", 128'(err), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
